// File: rtl/ram8_burst_reader.sv
// Burst read initiator for the RAM8 word store: walks consecutive addresses and streams each word over valid/ready.
// Optional RD_CHECKSUM_EN adds out_sum, a running modulo-2**DATA_W sum of the accepted words.
module ram8_burst_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef RD_CHECKSUM_EN
  output logic [DATA_W-1:0] out_sum,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  // Largest legal burst is one full pass over the address space.
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic [ADDR_W:0]     remaining_reg, remaining_next;
  logic                handshake;
  logic                burst_start;
`ifdef RD_CHECKSUM_EN
  logic [DATA_W-1:0]   out_sum_reg, out_sum_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      mem_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      remaining_reg <= '0;
`ifdef RD_CHECKSUM_EN
      out_sum_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_addr_reg  <= mem_addr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      remaining_reg <= remaining_next;
`ifdef RD_CHECKSUM_EN
      out_sum_reg   <= out_sum_next;
`endif
    end
  end

  assign handshake   = out_valid_reg & out_ready;
  assign burst_start = (state_reg == S_IDLE) && start && (len != '0);

  always_comb begin
    state_next     = state_reg;
    mem_addr_next  = mem_addr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      S_IDLE: begin
        if (burst_start) begin
          mem_addr_next  = start_addr;
          remaining_next = (len > MAX_LEN) ? MAX_LEN : len;
          state_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        // RAM8 read is combinational, so the word for mem_addr_reg is already present.
        out_data_next  = mem_data;
        out_valid_next = 1'b1;
        state_next     = S_HOLD;
      end
      S_HOLD: begin
        if (handshake) begin
          out_valid_next = 1'b0;
          if (remaining_reg == LEN_ONE) begin
            state_next = S_DONE;
          end else begin
            remaining_next = remaining_reg - LEN_ONE;
            mem_addr_next  = mem_addr_reg + ADDR_ONE;
            state_next     = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef RD_CHECKSUM_EN
  always_comb begin
    out_sum_next = out_sum_reg;
    if (burst_start) begin
      out_sum_next = '0;
    end else if (state_reg == S_HOLD && handshake) begin
      out_sum_next = out_sum_reg + out_data_reg;
    end
  end

  assign out_sum = out_sum_reg;
`endif

  assign mem_addr  = mem_addr_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);

endmodule
